// File: rtl/dtw_sequencer_if.sv
// rtl/dtw_sequencer_if.sv - command handshake bundle for the DTW sequencer
interface dtw_sequencer_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op;
  logic [31:0] i_cmd_ref_len;

  modport master (
    output i_cmd_valid,
    output i_cmd_op,
    output i_cmd_ref_len,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_op,
    input  i_cmd_ref_len,
    output o_cmd_ready
  );
endinterface

// File: rtl/dtw_sequencer.sv
// rtl/dtw_sequencer.sv - job sequencer driving a DTW core through reset, reference load and query runs
// Accepts LOAD/RUN commands, supervises the core with timeout/abort, reports sticky errors.
module dtw_sequencer #(
  parameter int RST_CYCLES = 4,
  parameter int TO_WIDTH   = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dtw_sequencer_if.slave       cmd,
  input  logic                 i_abort,
  input  logic [TO_WIDTH-1:0]  i_timeout,
  output logic                 o_core_rst,
  output logic                 o_core_rs,
  output logic                 o_core_mode,
  output logic [31:0]          o_core_ref_len,
  input  logic                 i_core_busy,
  input  logic                 i_core_load_done,
  output logic                 o_done_stb,
  output logic [1:0]           o_err,
  output logic                 o_ref_valid,
  output logic [2:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_job_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CRST     = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_RUN_ARM  = 3'd3;
  localparam logic [2:0] S_RUN_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [TO_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic                 job_load_q, job_load_d;
  logic [1:0]           err_q, err_d;
  logic                 ref_valid_q, ref_valid_d;
  logic [31:0]          ref_len_q, ref_len_d;
  logic [CNT_WIDTH-1:0] job_count_q, job_count_d;
  logic                 active;
  logic                 timeout_hit;

  assign active      = (state_q == S_LOAD) || (state_q == S_RUN_ARM) || (state_q == S_RUN_WAIT);
  assign cnt_inc     = cnt_q + TO_WIDTH'(1);
  // Fires on the cycle whose increment would reach the limit, so ERR lands exactly i_timeout cycles after entry.
  assign timeout_hit = (i_timeout != '0) && (cnt_inc == i_timeout);

  always_comb begin
    state_d     = state_q;
    cnt_d       = active ? cnt_inc : '0;
    rst_cnt_d   = '0;
    job_load_d  = job_load_q;
    err_d       = err_q;
    ref_valid_d = ref_valid_q;
    ref_len_d   = ref_len_q;
    job_count_d = job_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.i_cmd_valid) begin
          err_d = 2'd0;
          case (cmd.i_cmd_op)
            2'd0: begin
              ref_len_d   = cmd.i_cmd_ref_len;
              ref_valid_d = 1'b0;
              job_load_d  = 1'b1;
              state_d     = S_CRST;
            end
            2'd1: begin
              if (ref_valid_q) begin
                state_d = S_RUN_ARM;
              end else begin
                err_d   = 2'd2;
                state_d = S_ERR;
              end
            end
            default: begin
              err_d   = 2'd2;
              state_d = S_ERR;
            end
          endcase
        end
      end
      S_CRST: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d = job_load_q ? S_LOAD : S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      // Priority in active states: abort, then completion/progress, then timeout.
      S_LOAD: begin
        if (i_abort) begin
          err_d       = 2'd3;
          ref_valid_d = 1'b0;
          state_d     = S_ERR;
        end else if (i_core_load_done) begin
          ref_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 2'd1;
          state_d = S_ERR;
        end
      end
      S_RUN_ARM: begin
        if (i_abort) begin
          err_d   = 2'd3;
          state_d = S_ERR;
        end else if (i_core_busy) begin
          cnt_d   = '0;
          state_d = S_RUN_WAIT;
        end else if (timeout_hit) begin
          err_d   = 2'd1;
          state_d = S_ERR;
        end
      end
      S_RUN_WAIT: begin
        if (i_abort) begin
          err_d   = 2'd3;
          state_d = S_ERR;
        end else if (!i_core_busy) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 2'd1;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        job_count_d = job_count_q + CNT_WIDTH'(1);
        state_d     = S_IDLE;
      end
      S_ERR: begin
        job_load_d = 1'b0;
        state_d    = S_CRST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      job_load_q  <= 1'b0;
      err_q       <= 2'd0;
      ref_valid_q <= 1'b0;
      ref_len_q   <= '0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      job_load_q  <= job_load_d;
      err_q       <= err_d;
      ref_valid_q <= ref_valid_d;
      ref_len_q   <= ref_len_d;
      job_count_q <= job_count_d;
    end
  end

  // Core reset and ready follow rst combinationally so they are correct before the first edge.
  assign o_core_rst      = rst || (state_q == S_CRST);
  assign cmd.o_cmd_ready = !rst && (state_q == S_IDLE);
  assign o_core_rs       = active;
  assign o_core_mode     = (state_q == S_LOAD);
  assign o_core_ref_len  = ref_len_q;
  assign o_done_stb      = (state_q == S_DONE);
  assign o_err           = err_q;
  assign o_ref_valid     = ref_valid_q;
  assign o_state         = state_q;
  assign o_job_count     = job_count_q;

endmodule

// File: doc/dtw_sequencer.md
DTW_SEQUENCER -- requirements
Module: dtw_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 4: cycles o_core_rst is held per core reset.
REQ-002 Parameter TO_WIDTH, default 24: width of timeout counter and i_timeout.
REQ-003 Parameter CNT_WIDTH, default 16: width of o_job_count.
REQ-004 Port clk, in, 1: single clock; all logic is on its rising edge.
REQ-005 Port rst, in, 1: asynchronous, active-high reset.
REQ-006 Port i_cmd_valid, in, 1: command present.
REQ-007 Port o_cmd_ready, out, 1: sequencer can accept a command.
REQ-008 Port i_cmd_op, in, 2: 0 = LOAD reference, 1 = RUN query, 2/3 = illegal.
REQ-009 Port i_cmd_ref_len, in, 32: reference length, used by LOAD only.
REQ-010 Port i_abort, in, 1: level request to abort the current job.
REQ-011 Port i_timeout, in, TO_WIDTH: wait limit in cycles; 0 disables the timeout.
REQ-012 Port o_core_rst, out, 1: core reset.
REQ-013 Port o_core_rs, out, 1: core run/stop.
REQ-014 Port o_core_mode, out, 1: 1 = load reference, 0 = query.
REQ-015 Port o_core_ref_len, out, 32: latched reference length.
REQ-016 Port i_core_busy, in, 1: core busy status.
REQ-017 Port i_core_load_done, in, 1: core reference load complete.
REQ-018 Port o_done_stb, out, 1: one-cycle job-complete pulse.
REQ-019 Port o_err, out, 2: sticky error code: 0 none, 1 timeout, 2 illegal op / RUN without reference, 3 aborted.
REQ-020 Port o_ref_valid, out, 1: a reference is loaded.
REQ-021 Port o_state, out, 3: current state encoding, for debug.
REQ-022 Port o_job_count, out, CNT_WIDTH: count of successfully completed jobs.

Function
REQ-023 States and encodings: IDLE=0, CRST=1, LOAD=2, RUN_ARM=3, RUN_WAIT=4, DONE=5, ERR=6.
REQ-024 o_cmd_ready SHALL be 1 only in IDLE; a command is accepted when i_cmd_valid and o_cmd_ready are both 1.
REQ-025 On acceptance, o_err SHALL clear to 0.
REQ-026 Accepted LOAD SHALL latch i_cmd_ref_len into o_core_ref_len, clear o_ref_valid, and go to CRST.
REQ-027 Accepted RUN with o_ref_valid=1 SHALL go to RUN_ARM.
REQ-028 Accepted RUN with o_ref_valid=0, or an accepted illegal op, SHALL set o_err=2 and go to ERR.
REQ-029 CRST SHALL hold o_core_rst=1 for exactly RST_CYCLES cycles, then go to LOAD if the job is LOAD, else to IDLE.
REQ-030 LOAD SHALL drive o_core_rs=1 and o_core_mode=1; i_core_load_done=1 SHALL set o_ref_valid and go to DONE.
REQ-031 RUN_ARM SHALL drive o_core_rs=1 and o_core_mode=0, and go to RUN_WAIT when i_core_busy=1.
REQ-032 RUN_WAIT SHALL hold o_core_rs=1; i_core_busy=0 SHALL go to DONE.
REQ-033 o_core_rs SHALL be 0 in all other states.
REQ-034 A cycle counter SHALL clear on entry to LOAD, RUN_ARM and RUN_WAIT, and increment each cycle while in them.
REQ-035 If i_timeout!=0 and the counter reaches i_timeout, the sequencer SHALL set o_err=1 and go to ERR.
REQ-036 DONE SHALL last 1 cycle: assert o_done_stb, increment o_job_count (wrapping at max), and return to IDLE.
REQ-037 ERR SHALL last 1 cycle, then go to CRST with a reset-only job, which returns to IDLE.
REQ-038 i_abort=1 in LOAD, RUN_ARM or RUN_WAIT SHALL set o_err=3, clear o_ref_valid if in LOAD, and go to ERR next cycle.
REQ-039 i_abort SHALL be ignored in all other states.
REQ-040 If i_abort and a timeout occur in the same cycle, abort SHALL win (o_err=3).
REQ-041 If completion and a timeout occur in the same cycle, completion SHALL win.
REQ-042 A RUN job SHALL NOT pulse o_core_rst.

Reset
REQ-043 While rst=1, outputs SHALL be: state IDLE, o_core_rst=1, o_core_rs=0, o_core_mode=0, o_core_ref_len=0, o_err=0, o_ref_valid=0, o_done_stb=0, o_job_count=0, o_cmd_ready=0.
REQ-044 After rst deasserts, the sequencer SHALL enter IDLE with o_cmd_ready=1 on the first clock edge, and o_core_rst SHALL be 0.
REQ-045 rst asserted mid-job SHALL abandon the job immediately with no o_done_stb.

Verification
REQ-046 LOAD with ref_len=4000, load_done 10 cycles after LOAD entry -> o_core_rst high exactly 4 cycles, o_core_ref_len=4000, one o_done_stb, o_ref_valid=1, o_job_count=1.
REQ-047 RUN after load, busy high 3 cycles later for 20 cycles -> o_core_rs=1 throughout RUN_ARM/RUN_WAIT, o_done_stb 1 cycle after busy falls, o_job_count=2.
REQ-048 RUN from reset (no reference), and separately op=3 -> o_err=2, 4-cycle core reset, return to IDLE, no o_done_stb.
REQ-049 i_timeout=50 and busy never rises -> ERR 50 cycles after RUN_ARM entry, o_err=1, core reset pulse, o_ref_valid still 1.
REQ-050 i_abort during LOAD coincident with a timeout -> o_err=3, o_ref_valid=0; next accepted command clears o_err to 0.
REQ-051 rst asserted in RUN_WAIT -> all outputs at REQ-043 values asynchronously, before the next clock edge.
